inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the instruction buffer entries (fixed at 2 in this revision).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_addr  output  32  fetch address, word aligned.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction word returned, in request order.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect from execute.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port if_valid  output  1  instruction available to opcode decoder.
REQ-013 SHALL have port if_instr / if_pc  output  32/32  instruction word and its address.
REQ-014 SHALL have port if_opcode  output  7  if_instr[6:0], the decoder's opcode input.
REQ-015 SHALL have port id_ready  input  1  decoder consumes the instruction.

Function
REQ-016 SHALL implement states IDLE, RUN, FLUSH; IDLE -> RUN unconditionally one cycle after reset release.
REQ-017 SHALL in RUN assert imem_req_valid when (FIFO free slots - outstanding requests) > 0, with imem_req_addr = pc.
REQ-018 SHALL increment pc by 4 (mod 2^32, wrap FFFF_FFFC -> 0000_0000) on each accepted request (valid && ready).
REQ-019 SHALL hold at most 2 outstanding requests; a response pushes {pc_of_request, data} into the FIFO the same edge.
REQ-020 SHALL drive if_valid = FIFO non-empty && !redirect_valid; handshake = if_valid && id_ready pops one entry.
REQ-021 SHALL allow simultaneous push and pop when the FIFO is full; no overflow, no underflow, under any input sequence.
REQ-022 SHALL on redirect_valid: clear FIFO, set pc = redirect_pc, drop count = outstanding (including any response in that cycle); next state FLUSH if drop count > 0 else RUN.
REQ-023 SHALL in FLUSH issue no requests, discard each response and decrement drop count, returning to RUN when it reaches 0.
REQ-024 SHALL give redirect priority over any handshake, response push or request acceptance in the same cycle; a request accepted in that cycle is counted as outstanding and dropped.
REQ-025 SHALL latency: request accepted at cycle N with response at N+k yields if_valid at N+k+1.

Reset
REQ-026 SHALL on rst low, asynchronously: state IDLE, pc = RESET_PC, FIFO empty, outstanding = 0, drop count = 0, imem_req_valid = 0, if_valid = 0, if_instr/if_pc = 0.
REQ-027 SHALL on reset mid-operation abandon all in-flight requests; the memory side is reset in the same domain.

Configuration
REQ-028 SHALL, with FETCH_MISALIGN_TRAP_EN defined, add output fetch_misalign (1 bit): on a redirect with redirect_pc[1:0] != 0, set it, stop issuing requests, hold until reset or next aligned redirect.
REQ-029 SHALL, without FETCH_MISALIGN_TRAP_EN, have no fetch_misalign port and force redirect_pc[1:0] to 2'b00.

Structure
REQ-030 SHALL take state encodings, RESET_PC default and opcode width (7) from shared package cpu_pkg, also used by op_d.
REQ-031 SHALL implement the buffer as sub-module fetch_fifo (2 entries x 64 bits, push/pop/full/empty/clear).

Verification
REQ-032 Reset release, imem_req_ready=1, 1-cycle memory -> addresses 0x0,0x4,0x8 in successive cycles; if_pc follows with if_valid from cycle 3.
REQ-033 id_ready=0 for 10 cycles -> exactly 2 requests issued, FIFO full, imem_req_valid=0; id_ready=1 -> in-order 0x0,0x4 then resumes.
REQ-034 Redirect to 0x100 with 2 outstanding -> both stale responses discarded, next if_pc = 0x100, no stale instruction visible.
REQ-035 Redirect same cycle as handshake and response -> if_valid=0 that cycle, nothing consumed, FIFO empty after.
REQ-036 Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-037 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> fetch_misalign=1, no further requests until aligned redirect 0x200.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, buffer entry layout,
// reset PC default and opcode width (also used by op_d).
package cpu_pkg;

   localparam int          OPC_W        = 7;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer of {pc, instr} entries.
// Ports: clk, rst (async low), clear, push/wdata, pop/rdata, full, empty.
module fetch_fifo
   import cpu_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         push,
   input  fetch_entry_t wdata,
   input  logic         pop,
   output fetch_entry_t rdata,
   output logic         full,
   output logic         empty
);

   fetch_entry_t mem [2];
   logic         wp;
   logic         rp;
   logic [1:0]   cnt;
   logic         do_push;
   logic         do_pop;

   assign full    = (cnt == 2'd2);
   assign empty   = (cnt == 2'd0);
   assign do_pop  = pop && !empty;
   // a pop frees the slot this push needs when already full
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rp];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wp     <= 1'b0;
         rp     <= 1'b0;
         cnt    <= 2'd0;
      end else if (clear) begin
         wp  <= 1'b0;
         rp  <= 1'b0;
         cnt <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wp] <= wdata;
            wp      <= ~wp;
         end
         if (do_pop)
            rp <= ~rp;
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues sequential word fetches, buffers in-order
// responses and hands them to the opcode decoder; handles redirects.
// Ports: clk, rst (async low), imem_req_*, imem_rsp_*, redirect_*,
// if_valid/if_instr/if_pc/if_opcode, id_ready.
// Option FETCH_MISALIGN_TRAP_EN adds output fetch_misalign.
module inst_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req_valid,
   output logic [31:0]      imem_req_addr,
   input  logic             imem_req_ready,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic             if_valid,
   output logic [31:0]      if_instr,
   output logic [31:0]      if_pc,
   output logic [OPC_W-1:0] if_opcode,
   input  logic             id_ready
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic             fetch_misalign
`endif
);

   fetch_state_t state;
   fetch_state_t state_nxt;
   logic [31:0]  pc;
   logic [31:0]  tgt;
   logic [1:0]   outstanding;
   logic [1:0]   drop;
   logic [2:0]   pending;
   logic [2:0]   need;
   logic [2:0]   avail;
   logic [2:0]   drop_redir;
   logic [1:0]   fifo_cnt;
   logic         full;
   logic         empty;
   logic         rsp_hit;
   logic         pop;
   logic         push;
   logic         acc;
   logic         can_req;
   logic         halt;
   fetch_entry_t head;
   fetch_entry_t wdata;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q;

   assign tgt            = redirect_pc;
   assign halt           = misalign_q;
   assign fetch_misalign = misalign_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         misalign_q <= 1'b0;
      else if (redirect_valid)
         misalign_q <= (redirect_pc[1:0] != 2'b00);
   end
`else
   assign tgt  = redirect_pc & 32'hFFFF_FFFC;
   assign halt = 1'b0;
`endif

   assign fifo_cnt = full ? 2'd2 : (empty ? 2'd0 : 2'd1);
   assign pending  = {1'b0, outstanding} + {1'b0, drop};
   // unmatched responses are ignored so counters never underflow
   assign rsp_hit  = imem_rsp_valid && (pending != 3'd0);
   assign if_valid = !empty && !redirect_valid;
   assign pop      = if_valid && id_ready;
   // a same-cycle pop frees a slot for a new request
   assign need     = {1'b0, fifo_cnt} + pending;
   assign avail    = 3'(FIFO_DEPTH) + {2'b0, pop};
   assign can_req  = (need < avail);

   assign imem_req_valid = (state == RUN) && can_req && !halt;
   assign imem_req_addr  = pc;
   assign acc            = imem_req_valid && imem_req_ready;
   assign drop_redir     = pending + {2'b0, acc} - {2'b0, rsp_hit};

   // no redirect between requests, so the oldest in-flight
   // request sits outstanding words behind pc
   assign push        = rsp_hit && (state == RUN) && !redirect_valid;
   assign wdata.pc    = pc - {28'd0, outstanding, 2'b00};
   assign wdata.instr = imem_rsp_data;

   assign if_instr  = head.instr;
   assign if_pc     = head.pc;
   assign if_opcode = head.instr[OPC_W-1:0];

   fetch_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect_valid),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = RUN;
         RUN:     state_nxt = RUN;
         FLUSH: begin
            if (drop == 2'd0 || (drop == 2'd1 && rsp_hit))
               state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
      if (redirect_valid)
         state_nxt = (drop_redir != 3'd0) ? FLUSH : RUN;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= RESET_PC;
         outstanding <= 2'd0;
         drop        <= 2'd0;
      end else if (redirect_valid) begin
         pc          <= tgt;
         outstanding <= 2'd0;
         drop        <= drop_redir[1:0];
      end else begin
         if (acc)
            pc <= pc + 32'd4;
         outstanding <= outstanding + {1'b0, acc}
                        - {1'b0, rsp_hit && (state == RUN)};
         drop <= drop - {1'b0, rsp_hit && (state == FLUSH)};
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random
// traffic against an in-order memory and an expected-stream model.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = '0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [6:0]  if_opcode;
   logic        id_ready = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_misalign;
`endif

   inst_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_opcode      (if_opcode),
      .id_ready       (id_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misalign (fetch_misalign)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] acc_log[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          hs_cnt = 0;
   int          acc_cnt = 0;
   logic [31:0] exp_fetch = '0;
   logic [31:0] exp_if = '0;
   bit          exp_mis = 1'b0;
   logic        s_rv, s_iv;
   logic [31:0] s_ra, s_ipc;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      id_ready = 1'b0;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      #1;
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_instr", if_instr, 32'd0);
      mq.delete();
      exp_fetch = 32'h0;
      exp_if = 32'h0;
      exp_mis = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
   endtask

   task automatic step(input bit idr, input bit rr, input bit redir,
                       input logic [31:0] tgt, input int lat);
      logic [31:0] w;
      logic [31:0] t;
      @(negedge clk);
      id_ready = idr;
      imem_req_ready = rr;
      redirect_valid = redir;
      redirect_pc = tgt;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data = word_of(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data = $urandom;
      end
      #1;
      s_rv = imem_req_valid;
      s_ra = imem_req_addr;
      s_iv = if_valid;
      s_ipc = if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("misalign_flag", {31'd0, fetch_misalign}, {31'd0, exp_mis});
      if (exp_mis)
         chk("misalign_halt", {31'd0, s_rv}, 32'd0);
`endif
      if (s_rv && rr) begin
         chk("req_addr", s_ra, exp_fetch);
         mq.push_back('{addr: s_ra, due: cyc + lat});
         acc_log.push_back(s_ra);
         chk("outstanding_bound", {31'd0, mq.size() <= 2}, 32'd1);
         exp_fetch = exp_fetch + 32'd4;
         acc_cnt++;
      end
      if (redir) begin
         chk("redir_if_valid", {31'd0, s_iv}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
         t = tgt;
         exp_mis = (tgt[1:0] != 2'b00);
`else
         t = {tgt[31:2], 2'b00};
`endif
         exp_fetch = t;
         exp_if = t;
      end else if (s_iv) begin
         chk("if_pc", s_ipc, exp_if);
         if (idr) begin
            w = word_of(exp_if);
            chk("if_instr", if_instr, w);
            chk("if_opcode", {25'd0, if_opcode}, {25'd0, w[6:0]});
            exp_if = exp_if + 32'd4;
            hs_cnt++;
         end
      end
      @(posedge clk);
      cyc++;
   endtask

   logic        rv[6];
   logic        iv[6];
   logic [31:0] ra[6];
   logic [31:0] ipc[6];
   int          base;

   initial begin
      // back-to-back fetch with a 1-cycle memory
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 0, 32'h0, 1);
         rv[i] = s_rv;
         ra[i] = s_ra;
         iv[i] = s_iv;
         ipc[i] = s_ipc;
      end
      chk("c0_req_valid", {31'd0, rv[0]}, 32'd0);
      chk("c1_req", {31'd0, rv[1]}, 32'd1);
      chk("c1_addr", ra[1], 32'h0);
      chk("c2_addr", ra[2], 32'h4);
      chk("c3_req", {31'd0, rv[3]}, 32'd1);
      chk("c3_addr", ra[3], 32'h8);
      chk("c2_if_valid", {31'd0, iv[2]}, 32'd0);
      chk("c3_if_valid", {31'd0, iv[3]}, 32'd1);
      chk("c3_if_pc", ipc[3], 32'h0);
      chk("c4_if_pc", ipc[4], 32'h4);

      // decoder stall: buffer fills with exactly two words
      do_reset();
      base = acc_cnt;
      repeat (11) step(0, 1, 0, 32'h0, 1);
      chk("stall_req_count", acc_cnt - base, 2);
      chk("stall_req_valid", {31'd0, s_rv}, 32'd0);
      chk("stall_if_valid", {31'd0, s_iv}, 32'd1);
      base = hs_cnt;
      repeat (6) step(1, 1, 0, 32'h0, 1);
      chk("stall_resume", {31'd0, (hs_cnt - base) >= 2}, 32'd1);

      // redirect with two requests in flight
      do_reset();
      repeat (3) step(1, 1, 0, 32'h0, 3);
      step(1, 1, 1, 32'h100, 3);
      base = hs_cnt;
      repeat (12) step(1, 1, 0, 32'h0, 1);
      chk("redir_progress", {31'd0, hs_cnt > base}, 32'd1);

      // redirect collides with handshake and response
      do_reset();
      repeat (3) step(0, 1, 0, 32'h0, 1);
      step(1, 1, 1, 32'h40, 1);
      step(1, 0, 0, 32'h0, 1);
      chk("collide_empty_after", {31'd0, s_iv}, 32'd0);
      repeat (5) step(1, 1, 0, 32'h0, 1);

      // address wrap
      step(1, 1, 1, 32'hFFFF_FFFC, 1);
      acc_log.delete();
      repeat (8) step(1, 1, 0, 32'h0, 1);
      chk("wrap_first", acc_log[0], 32'hFFFF_FFFC);
      chk("wrap_second", acc_log[1], 32'h0000_0000);

`ifdef FETCH_MISALIGN_TRAP_EN
      step(1, 1, 1, 32'h102, 1);
      repeat (6) step(1, 1, 0, 32'h0, 1);
      step(1, 1, 1, 32'h200, 1);
      acc_log.delete();
      repeat (6) step(1, 1, 0, 32'h0, 1);
      chk("realign_first", acc_log[0], 32'h200);
`endif

      // random traffic, one mid-run reset
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         if (i == 1500)
            do_reset();
         t = $urandom;
         if ($urandom_range(0, 3) == 0)
            t = 32'hFFFF_FFF0 | (t & 32'hF);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 24) == 0, t, $urandom_range(1, 4));
      end
      step(1, 1, 1, 32'h400, 1);
      base = hs_cnt;
      repeat (20) step(1, 1, 0, 32'h0, 1);
      chk("drain_progress", {31'd0, hs_cnt > base}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
